dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port byte-addressed data memory.
- Port 0 is the core MEM stage. Port 1 is the debug/program loader.
- Forwards one access per cycle to the memory, returns read data with the memory's 1-cycle registered latency, rejects out-of-range or illegal-size accesses, and supports bounded exclusive locking.

---
 rtl/dmem_port_if.sv | 26 ++
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_if.sv
// One requester port of the data-memory arbiter: request fields, grant and read response.
// Handshake: the master raises req with stable we/sec/addr/wdata/lock and holds them until
// it sees gnt in the same cycle. gnt is combinational. rvalid is a one-cycle pulse (no
// backpressure) that carries rdata and err for the access granted in the previous cycle.
interface dmem_port_if;
    logic        req;
    logic        we;
    logic [1:0]  sec;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, sec, addr, wdata, lock,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, sec, addr, wdata, lock,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory: round-robin grants,
// bounded exclusive locking, range checking and 1-cycle registered read return.
module dmem_arbiter #(
    parameter int unsigned MEM_TOP  = 20,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    dmem_port_if.slave  p0,
    dmem_port_if.slave  p1,
    output logic        mem_rw_o,
    output logic [1:0]  mem_sec_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_data_i,
    output logic [1:0]  state_o      // 0 ARB, 1 LOCK0, 2 LOCK1
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            rr_q, rr_d;        // 0: port 0 wins a conflict, 1: port 1 wins
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      rv_q, rv_d;
    logic [1:0]      err_q, err_d;

    logic            gnt0, gnt1;
    logic            win_any;
    logic            win_we;
    logic [1:0]      win_sec;
    logic [31:0]     win_addr;
    logic [31:0]     win_wdata;
    logic            win_lock;
    logic            win_ok;

    // 33-bit end address so accesses near 2^32 cannot wrap into range.
    function automatic logic access_ok(input logic [1:0] sec, input logic [31:0] addr);
        logic [32:0] last;
        case (sec)
            2'b00:   last = {1'b0, addr};
            2'b01:   last = {1'b0, addr} + 33'd1;
            2'b10:   last = {1'b0, addr} + 33'd3;
            default: last = '1;
        endcase
        return (sec != 2'b11) && (last <= 33'(MEM_TOP));
    endfunction

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    if (p0.req && (!p1.req || !rr_q)) begin
                        gnt0 = 1'b1;
                    end else if (p1.req) begin
                        gnt1 = 1'b1;
                    end
                    if (gnt0 || gnt1) begin
                        rr_d = ~rr_q;
                        if (win_lock) begin
                            cnt_d = CW'(1);
                            if (MAX_LOCK > 1) begin
                                state_d = gnt0 ? LOCK0 : LOCK1;
                            end
                        end
                    end
                end
                LOCK0: begin
                    gnt0  = p0.req;
                    cnt_d = cnt_q + CW'(1);
                    if (!p0.lock || cnt_d >= CW'(MAX_LOCK)) begin
                        state_d = ARB;
                        rr_d    = 1'b1;
                    end
                end
                LOCK1: begin
                    gnt1  = p1.req;
                    cnt_d = cnt_q + CW'(1);
                    if (!p1.lock || cnt_d >= CW'(MAX_LOCK)) begin
                        state_d = ARB;
                        rr_d    = 1'b0;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    // Fields of whichever port won this cycle.
    always_comb begin
        win_any   = gnt0 | gnt1;
        win_we    = gnt1 ? p1.we    : p0.we;
        win_sec   = gnt1 ? p1.sec   : p0.sec;
        win_addr  = gnt1 ? p1.addr  : p0.addr;
        win_wdata = gnt1 ? p1.wdata : p0.wdata;
        win_lock  = gnt1 ? p1.lock  : p0.lock;
        win_ok    = access_ok(win_sec, win_addr);
    end

    always_comb begin
        mem_rw_o    = 1'b0;
        mem_sec_o   = 2'b11;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (win_any && win_ok) begin
            mem_rw_o    = win_we;
            mem_sec_o   = win_sec;
            mem_addr_o  = win_addr;
            mem_wdata_o = win_wdata;
        end
    end

    // Rejected accesses answer with an error pulse whether they were reads or writes.
    always_comb begin
        rv_d[0]  = gnt0 && (!win_ok || !win_we);
        rv_d[1]  = gnt1 && (!win_ok || !win_we);
        err_d[0] = gnt0 && !win_ok;
        err_d[1] = gnt1 && !win_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            rv_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign p0.rvalid = rv_q[0] & ~rst;
    assign p1.rvalid = rv_q[1] & ~rst;
    assign p0.err    = err_q[0] & ~rst;
    assign p1.err    = err_q[1] & ~rst;
    assign p0.rdata  = (rv_q[0] && !err_q[0] && !rst) ? mem_data_i : '0;
    assign p1.rdata  = (rv_q[1] && !err_q[1] && !rst) ? mem_data_i : '0;
    assign state_o   = state_q;

    a_gnt_onehot: assert property (@(posedge clk) !(gnt0 && gnt1));
    a_no_write_in_rst: assert property (@(posedge clk) rst |-> !mem_rw_o);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, all checked against a
// cycle-level reference model with its own byte-array copy of the memory.
module tb_dmem_arbiter;
    localparam int unsigned MEM_TOP  = 20;
    localparam int unsigned MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rw;
    logic [1:0]  mem_sec;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_data = '0;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    dmem_port_if p0_if ();
    dmem_port_if p1_if ();

    dmem_arbiter #(.MEM_TOP(MEM_TOP), .MAX_LOCK(MAX_LOCK)) dut (
        .clk         (clk),
        .rst         (rst),
        .p0          (p0_if),
        .p1          (p1_if),
        .mem_rw_o    (mem_rw),
        .mem_sec_o   (mem_sec),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_data_i  (mem_data),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    function automatic int sec_bytes(input logic [1:0] sec);
        return (sec == 2'b00) ? 1 : (sec == 2'b01) ? 2 : 4;
    endfunction

    // Environment memory: little-endian bytes, registered read, garbage when idle.
    logic [7:0] env_mem [0:MEM_TOP] = '{default: 8'h00};
    always @(posedge clk) begin
        logic [31:0] rd;
        rd = $urandom;
        if (mem_sec != 2'b11) begin
            rd = '0;
            for (int i = 0; i < sec_bytes(mem_sec); i++) begin
                if ({32'd0, mem_addr} + 64'(i) <= 64'(MEM_TOP)) begin
                    rd = rd | ({24'd0, env_mem[int'(mem_addr) + i]} << (8 * i));
                    if (mem_rw) env_mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
                end
            end
        end
        mem_data <= rd;
    end

    // Reference model state
    logic [7:0]  ref_mem [0:MEM_TOP] = '{default: 8'h00};
    int          m_rr    = 0;
    int          m_owner = -1;
    int          m_cnt   = 0;
    int          m_win   = -1;
    logic        m_pv [2] = '{1'b0, 1'b0};
    logic        m_pe [2] = '{1'b0, 1'b0};
    logic [31:0] m_pd [2] = '{32'd0, 32'd0};

    logic [1:0]  rng_sec  [3] = '{2'b10, 2'b11, 2'b00};
    logic [31:0] rng_addr [3] = '{32'd18, 32'd0, 32'hFFFF_FFFF};
    logic        rng_we   [3] = '{1'b0, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic req, input logic we, input logic [1:0] sec,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
        if (k == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.sec = sec;
            p0_if.addr = addr; p0_if.wdata = wdata; p0_if.lock = lock;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.sec = sec;
            p1_if.addr = addr; p1_if.wdata = wdata; p1_if.lock = lock;
        end
    endtask

    task automatic drive_rand(input int k, input logic lock);
        logic [1:0]  sec;
        logic [31:0] addr;
        sec  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        addr = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                            : 32'($urandom_range(0, MEM_TOP + 2));
        drive(k, 1'b1, 1'($urandom_range(0, 1)), sec, addr, $urandom, lock);
    endtask

    // Settle inputs, predict this cycle from the rules, compare, advance the model a cycle.
    task automatic cycle();
        logic        rq [2];
        logic        we [2];
        logic        lk [2];
        logic [1:0]  sc [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        int          w;
        int          nb;
        logic        lg;
        logic        e_rw;
        logic [1:0]  e_sec;
        logic [31:0] e_addr, e_wd, rd;
        #1;
        rq[0] = p0_if.req;  we[0] = p0_if.we;  lk[0] = p0_if.lock;
        sc[0] = p0_if.sec;  ad[0] = p0_if.addr; wd[0] = p0_if.wdata;
        rq[1] = p1_if.req;  we[1] = p1_if.we;  lk[1] = p1_if.lock;
        sc[1] = p1_if.sec;  ad[1] = p1_if.addr; wd[1] = p1_if.wdata;

        w = -1;
        if (!rst) begin
            if (m_owner >= 0) begin
                if (rq[m_owner]) w = m_owner;
            end else if (rq[0] && rq[1]) w = m_rr;
            else if (rq[0]) w = 0;
            else if (rq[1]) w = 1;
        end
        lg = 1'b0; nb = 1; e_rw = 1'b0; e_sec = 2'b11; e_addr = '0; e_wd = '0;
        if (w >= 0) begin
            nb = sec_bytes(sc[w]);
            lg = (sc[w] != 2'b11) && ({32'd0, ad[w]} + 64'(nb) - 64'd1 <= 64'(MEM_TOP));
            if (lg) begin
                e_rw = we[w]; e_sec = sc[w]; e_addr = ad[w]; e_wd = wd[w];
            end
        end

        chk("gnt0", p0_if.gnt, w == 0);
        chk("gnt1", p1_if.gnt, w == 1);
        chk("mem_rw", mem_rw, e_rw);
        chk("mem_sec", mem_sec, e_sec);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("rvalid0", p0_if.rvalid, !rst && m_pv[0]);
        chk("rvalid1", p1_if.rvalid, !rst && m_pv[1]);
        chk("err0", p0_if.err, !rst && m_pe[0]);
        chk("err1", p1_if.err, !rst && m_pe[1]);
        chk("rdata0", p0_if.rdata, (!rst && m_pv[0]) ? m_pd[0] : 32'd0);
        chk("rdata1", p1_if.rdata, (!rst && m_pv[1]) ? m_pd[1] : 32'd0);
        chk("state", state, (m_owner < 0) ? 32'd0 : 32'(m_owner + 1));

        m_win = w;
        m_pv = '{1'b0, 1'b0};
        m_pe = '{1'b0, 1'b0};
        m_pd = '{32'd0, 32'd0};
        if (rst) begin
            m_owner = -1; m_rr = 0; m_cnt = 0;
        end else begin
            if (w >= 0) begin
                if (!lg) begin
                    m_pv[w] = 1'b1; m_pe[w] = 1'b1;
                end else if (!we[w]) begin
                    rd = '0;
                    for (int i = 0; i < nb; i++) rd = rd | ({24'd0, ref_mem[ad[w] + i]} << (8 * i));
                    m_pv[w] = 1'b1; m_pd[w] = rd;
                end else begin
                    for (int i = 0; i < nb; i++) ref_mem[ad[w] + i] = wd[w][8*i +: 8];
                end
            end
            if (m_owner < 0) begin
                if (w >= 0) begin
                    m_rr = 1 - m_rr;
                    if (lk[w]) begin
                        m_cnt = 1;
                        if (m_cnt < MAX_LOCK) m_owner = w;
                    end
                end
            end else begin
                m_cnt++;
                if (!lk[m_owner] || m_cnt >= MAX_LOCK) begin
                    m_rr = 1 - m_owner;
                    m_owner = -1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run_random(input int n);
        logic cur_req, cur_lock, new_lock;
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < 2; k++) begin
                cur_req  = (k == 0) ? p0_if.req  : p1_if.req;
                cur_lock = (k == 0) ? p0_if.lock : p1_if.lock;
                if (!cur_req || m_win == k) begin
                    if ($urandom_range(0, 3) != 0) drive_rand(k, 1'b0);
                    else drive(k, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
                end
                new_lock = cur_lock ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
                if (k == 0) p0_if.lock = new_lock;
                else p1_if.lock = new_lock;
            end
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
    endtask

    initial begin
        drive(0, 1'b1, 1'b1, 2'b00, 32'd0, 32'h0000_00FF, 1'b0);
        drive(1, 1'b1, 1'b0, 2'b10, 32'd4, 32'd0, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        // Reset held two cycles with both ports requesting
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_gnt", {p1_if.gnt, p0_if.gnt}, 2'b00);
            chk("rst_sec", mem_sec, 2'b11);
            cycle();
        end
        rst = 1'b0;

        // Byte write then read back
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        drive(0, 1'b1, 1'b1, 2'b00, 32'd3, 32'h1234_56A5, 1'b0);
        #1;
        chk("rst_state", state, 2'd0);
        chk("wr_gnt", p0_if.gnt, 1'b1);
        chk("wr_rw", mem_rw, 1'b1);
        cycle();
        drive(0, 1'b1, 1'b0, 2'b00, 32'd3, 32'd0, 1'b0);
        cycle();
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        #1;
        chk("rd_rvalid", p0_if.rvalid, 1'b1);
        chk("rd_data", p0_if.rdata, 32'h0000_00A5);
        chk("rd_err", p0_if.err, 1'b0);
        cycle();

        // Conflict: both read every cycle, grants alternate starting with p0
        drive(0, 1'b1, 1'b0, 2'b00, 32'($urandom_range(0, MEM_TOP)), 32'd0, 1'b0);
        drive(1, 1'b1, 1'b0, 2'b00, 32'($urandom_range(0, MEM_TOP)), 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("alt_gnt", {p1_if.gnt, p0_if.gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) chk("alt_rv", {p1_if.rvalid, p0_if.rvalid}, (i % 2 == 0) ? 2'b10 : 2'b01);
            cycle();
            drive(m_win, 1'b1, 1'b0, 2'b00, 32'($urandom_range(0, MEM_TOP)), 32'd0, 1'b0);
        end
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        #1;
        chk("alt_rv_last", {p1_if.rvalid, p0_if.rvalid}, 2'b10);
        cycle();

        // Lock: p1 holds lock for MAX_LOCK grants while p0 waits, then p0 wins
        drive(1, 1'b1, 1'b0, 2'b00, 32'd3, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("lock_gnt", {p1_if.gnt, p0_if.gnt}, (i < 4) ? 2'b10 : 2'b01);
            cycle();
            if (i == 0) drive(0, 1'b1, 1'b0, 2'b00, 32'd3, 32'd0, 1'b0);
            if (m_win == 1) drive(1, 1'b1, 1'b0, 2'b00, 32'($urandom_range(0, MEM_TOP)), 32'd0, 1'b1);
        end
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        cycle();

        // Range errors: word at 18, illegal size, byte at the top of the address space
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, rng_we[i], rng_sec[i], rng_addr[i], $urandom, 1'b0);
            #1;
            chk("rng_gnt", p0_if.gnt, 1'b1);
            chk("rng_rw", mem_rw, 1'b0);
            if (i > 0) chk("rng_err", {p0_if.rvalid, p0_if.err, |p0_if.rdata}, 3'b110);
            cycle();
        end
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        #1;
        chk("rng_err", {p0_if.rvalid, p0_if.err, |p0_if.rdata}, 3'b110);
        cycle();

        // Reset while p1 owns the lock with a read in flight
        drive(1, 1'b1, 1'b0, 2'b00, 32'd5, 32'd0, 1'b1);
        cycle();
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 2'b00, 32'd7, 32'd0, 1'b0);
        #1;
        chk("mrst_pre_state", state, 2'd2);
        chk("mrst_rv1", p1_if.rvalid, 1'b0);
        cycle();
        rst = 1'b0;
        #1;
        chk("mrst_state", state, 2'd0);
        chk("mrst_gnt", {p1_if.gnt, p0_if.gnt}, 2'b01);
        cycle();

        run_random(800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
